// File: rtl/clock12_timekeeper.sv
// clock12_timekeeper: free-running 12-hour time-of-day counter (isPM, hours 1..12,
//   minutes/seconds 0..59) with a one-cycle second tick, direct load and manual inc.
// Latency: every input event in cycle N appears on the registered outputs in cycle N+1.
// Backpressure: none; run=0 freezes the prescaler and time, while load/inc still apply.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset, overrides everything
//   run          1 = timekeeping advances, 0 = prescaler and time frozen
//   load         one-cycle strobe: load loadIsPM/loadHours/loadMinutes
//   loadIsPM     load value, 1 = PM
//   loadHours    load value, legal 1..12
//   loadMinutes  load value, legal 0..59
//   incHour      one-cycle strobe: advance hour (12-hour rules)
//   incMinute    one-cycle strobe: advance minute mod 60, no carry into hours
//   isPM         registered, 0 = AM, 1 = PM
//   hours        registered, 1..12
//   minutes      registered, 0..59
//   seconds      registered, 0..59
//   secTick      registered one-cycle pulse when seconds advance from the prescaler
//   loadErr      registered one-cycle pulse when a load is rejected as out of range
module clock12_timekeeper #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESCALE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic       loadIsPM,
  input  logic [3:0] loadHours,
  input  logic [5:0] loadMinutes,
  input  logic       incHour,
  input  logic       incMinute,
  output logic       isPM,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       secTick,
  output logic       loadErr
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  // Registered state
  logic [PRESCALE_W-1:0] presc_q;
  logic                  pm_q;
  logic [3:0]            hours_q;
  logic [5:0]            minutes_q;
  logic [5:0]            seconds_q;
  logic                  tick_q;
  logic                  err_q;

  // Next-state values
  logic [PRESCALE_W-1:0] presc_d;
  logic                  pm_d;
  logic [3:0]            hours_d;
  logic [5:0]            minutes_d;
  logic [5:0]            seconds_d;
  logic                  tick_d;
  logic                  err_d;

  // Single-step advance values, shared by the carry chain and the inc strobes
  logic [3:0] hour_adv;
  logic       pm_adv;
  logic [5:0] min_adv;
  logic       min_wrap;
  logic [5:0] sec_adv;
  logic       sec_wrap;
  logic       presc_term;
  logic       load_ok;
  logic       any_inc;

  always_comb begin
    // 12 -> 1 keeps AM/PM; 11 -> 12 is the noon/midnight boundary and flips it.
    hour_adv = (hours_q == 4'd12) ? 4'd1 : hours_q + 4'd1;
    pm_adv   = (hours_q == 4'd11) ? ~pm_q : pm_q;

    min_wrap = (minutes_q == 6'd59);
    min_adv  = min_wrap ? 6'd0 : minutes_q + 6'd1;

    sec_wrap = (seconds_q == 6'd59);
    sec_adv  = sec_wrap ? 6'd0 : seconds_q + 6'd1;

    presc_term = (presc_q == PRESC_LAST);
    load_ok    = (loadHours != 4'd0) && (loadHours <= 4'd12) && (loadMinutes <= 6'd59);
    any_inc    = incHour | incMinute;
  end

  // Priority: load > inc strobes > prescaler. A tick that coincides with a load
  // or inc is simply lost; nothing is queued for later.
  always_comb begin
    presc_d   = presc_q;
    pm_d      = pm_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;

    if (load) begin
      if (load_ok) begin
        pm_d      = loadIsPM;
        hours_d   = loadHours;
        minutes_d = loadMinutes;
        seconds_d = 6'd0;
        presc_d   = '0;
      end else begin
        // Rejected load leaves every piece of state, prescaler included, untouched.
        err_d = 1'b1;
      end
    end else if (any_inc) begin
      if (incHour) begin
        hours_d = hour_adv;
        pm_d    = pm_adv;
      end
      if (incMinute) begin
        minutes_d = min_adv;
      end
      seconds_d = 6'd0;
      presc_d   = '0;
    end else if (run) begin
      if (presc_term) begin
        presc_d   = '0;
        tick_d    = 1'b1;
        seconds_d = sec_adv;
        if (sec_wrap) begin
          minutes_d = min_adv;
          if (min_wrap) begin
            hours_d = hour_adv;
            pm_d    = pm_adv;
          end
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      pm_q      <= 1'b0;
      hours_q   <= 4'd12;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pm_q      <= pm_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign isPM    = pm_q;
  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign secTick = tick_q;
  assign loadErr = err_q;

endmodule

// File: tb/tb_clock12_timekeeper.sv
// tb_clock12_timekeeper: directed stimulus for clock12_timekeeper with TICKS_PER_SEC=4.
// Stimulus queues the expected output snapshot for a given cycle; a negedge monitor
// pops and compares each snapshot in the cycle it targets.
module tb_clock12_timekeeper;

  logic       clk = 1'b0;
  logic       reset, run, load, loadIsPM, incHour, incMinute;
  logic [3:0] loadHours;
  logic [5:0] loadMinutes;
  logic       isPM, secTick, loadErr;
  logic [3:0] hours;
  logic [5:0] minutes, seconds;

  clock12_timekeeper #(.TICKS_PER_SEC(4), .PRESCALE_W(3)) dut (
    .clk(clk), .reset(reset), .run(run), .load(load), .loadIsPM(loadIsPM),
    .loadHours(loadHours), .loadMinutes(loadMinutes), .incHour(incHour),
    .incMinute(incMinute), .isPM(isPM), .hours(hours), .minutes(minutes),
    .seconds(seconds), .secTick(secTick), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int pm;
    int h;
    int m;
    int s;
    int tk;
    int er;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc_n = 0;
  int    checks = 0;
  int    fails = 0;
  exp_t  e;
  string nm;

  always @(posedge clk) cyc_n = cyc_n + 1;

  // Monitor: compare every snapshot whose target cycle has been reached.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc_n ||
          int'(isPM) != e.pm || int'(hours) != e.h || int'(minutes) != e.m ||
          int'(seconds) != e.s || int'(secTick) != e.tk || int'(loadErr) != e.er) begin
        fails = fails + 1;
        $display("FAIL %s cyc=%0d(want %0d): got pm=%0d %0d:%0d:%0d tick=%0d err=%0d, want pm=%0d %0d:%0d:%0d tick=%0d err=%0d",
                 nm, cyc_n, e.cyc, isPM, hours, minutes, seconds, secTick, loadErr,
                 e.pm, e.h, e.m, e.s, e.tk, e.er);
      end
    end
  end

  // Queue an expected snapshot dc cycles after the current one.
  task automatic expect_at(input int dc, input int pm, input int h, input int m,
                           input int s, input int tk, input int er, input string n);
    exp_t x;
    x.cyc = cyc_n + dc;
    x.pm = pm; x.h = h; x.m = m; x.s = s; x.tk = tk; x.er = er;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic pm, input logic [3:0] h, input logic [5:0] m);
    load = 1'b1; loadIsPM = pm; loadHours = h; loadMinutes = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; load = 1'b0; loadIsPM = 1'b0;
    loadHours = 4'd0; loadMinutes = 6'd0; incHour = 1'b0; incMinute = 1'b0;
    step(1);
    expect_at(1, 0, 12, 0, 0, 0, 0, "reset_state");
    step(1);
    reset = 1'b0;

    // Tick every 4th running cycle; 2 seconds after 8 cycles.
    run = 1'b1;
    for (int k = 1; k <= 8; k++)
      expect_at(k, 0, 12, 0, k / 4, (k % 4 == 0) ? 1 : 0, 0, "run_8_cycles");
    step(8);
    checks = checks + 1;
    if (seconds !== 6'd2 || secTick !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL direct_run_8: seconds=%0d secTick=%0d, want 2/1", seconds, secTick);
    end
    run = 1'b0;

    // 11:59 PM, then one minute of running rolls to 12:00:00 AM.
    do_load(1'b1, 4'd11, 6'd59);
    expect_at(1, 1, 11, 59, 0, 0, 0, "load_1159pm");
    step(1);
    checks = checks + 1;
    if (isPM !== 1'b1 || hours !== 4'd11 || minutes !== 6'd59) begin
      fails = fails + 1;
      $display("FAIL direct_load_1159pm: pm=%0d %0d:%0d", isPM, hours, minutes);
    end
    load = 1'b0; run = 1'b1;
    expect_at(236, 1, 11, 59, 59, 1, 0, "at_115959pm");
    expect_at(240, 0, 12, 0, 0, 1, 0, "midnight_rollover");
    step(240);
    checks = checks + 1;
    if (isPM !== 1'b0 || hours !== 4'd12 || minutes !== 6'd0 || seconds !== 6'd0) begin
      fails = fails + 1;
      $display("FAIL direct_midnight: pm=%0d %0d:%0d:%0d", isPM, hours, minutes, seconds);
    end
    run = 1'b0;

    // 12:59 AM rolls to 1:00 AM without toggling AM/PM.
    do_load(1'b0, 4'd12, 6'd59);
    expect_at(1, 0, 12, 59, 0, 0, 0, "load_1259am");
    step(1);
    load = 1'b0; run = 1'b1;
    expect_at(240, 0, 1, 0, 0, 1, 0, "12_to_1_no_toggle");
    step(240);
    checks = checks + 1;
    if (hours !== 4'd1 || isPM !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL direct_12_to_1: pm=%0d hours=%0d", isPM, hours);
    end
    run = 1'b0;

    // Out-of-range loads are rejected and time is preserved.
    do_load(1'b1, 4'd13, 6'd5);
    expect_at(1, 0, 1, 0, 0, 0, 1, "load_hours13_err");
    step(1);
    load = 1'b0;
    expect_at(1, 0, 1, 0, 0, 0, 0, "loaderr_one_cycle");
    step(1);
    do_load(1'b0, 4'd0, 6'd10);
    expect_at(1, 0, 1, 0, 0, 0, 1, "load_hours0_err");
    step(1);
    load = 1'b0;
    expect_at(1, 0, 1, 0, 0, 0, 0, "loaderr_clear2");
    step(1);
    do_load(1'b0, 4'd5, 6'd60);
    expect_at(1, 0, 1, 0, 0, 0, 1, "load_min60_err");
    step(1);
    load = 1'b0;

    // 10:59:30 AM, incMinute wraps minutes with no hour carry.
    do_load(1'b0, 4'd10, 6'd59);
    step(1);
    load = 1'b0; run = 1'b1;
    expect_at(120, 0, 10, 59, 30, 1, 0, "at_105930am");
    step(120);
    run = 1'b0; incMinute = 1'b1;
    expect_at(1, 0, 10, 0, 0, 0, 0, "incmin_no_carry");
    step(1);
    checks = checks + 1;
    if (hours !== 4'd10 || minutes !== 6'd0 || seconds !== 6'd0) begin
      fails = fails + 1;
      $display("FAIL direct_incmin: %0d:%0d:%0d", hours, minutes, seconds);
    end
    incMinute = 1'b0;

    // incHour: 11 AM -> 12 PM -> 1 PM.
    do_load(1'b0, 4'd11, 6'd20);
    step(1);
    load = 1'b0; incHour = 1'b1;
    expect_at(1, 1, 12, 20, 0, 0, 0, "inchour_11am_12pm");
    step(1);
    expect_at(1, 1, 1, 20, 0, 0, 0, "inchour_12pm_1pm");
    step(1);
    incHour = 1'b0;

    // incHour in the terminal-count cycle: tick discarded, prescaler restarts.
    run = 1'b1;
    expect_at(3, 1, 1, 20, 0, 0, 0, "pre_terminal");
    step(3);
    incHour = 1'b1;
    expect_at(1, 1, 2, 20, 0, 0, 0, "inchour_at_terminal");
    step(1);
    incHour = 1'b0;
    expect_at(3, 1, 2, 20, 0, 0, 0, "presc_restart_no_tick");
    expect_at(4, 1, 2, 20, 1, 1, 0, "presc_restart_tick");
    step(4);
    run = 1'b0;

    // Reset at 05:17:33 PM with prescaler=2.
    do_load(1'b1, 4'd5, 6'd17);
    step(1);
    load = 1'b0; run = 1'b1;
    expect_at(132, 1, 5, 17, 33, 1, 0, "at_051733pm");
    expect_at(134, 1, 5, 17, 33, 0, 0, "presc_at_2");
    step(134);
    reset = 1'b1;
    expect_at(1, 0, 12, 0, 0, 0, 0, "mid_reset");
    step(1);
    reset = 1'b0;
    expect_at(3, 0, 12, 0, 0, 0, 0, "post_reset_no_tick");
    expect_at(4, 0, 12, 0, 1, 1, 0, "post_reset_tick");
    step(4);
    run = 1'b0;

    // Load wins over a simultaneous incMinute.
    do_load(1'b0, 4'd3, 6'd45);
    incMinute = 1'b1;
    expect_at(1, 0, 3, 45, 0, 0, 0, "load_beats_incmin");
    step(1);
    load = 1'b0;
    // Both strobes together apply independently.
    incHour = 1'b1;
    expect_at(1, 0, 4, 46, 0, 0, 0, "both_inc");
    step(1);
    incHour = 1'b0; incMinute = 1'b0;

    // Bounded drain of any pending checks.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1);
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks = checks + 1;
      fails  = fails + 1;
      $display("FAIL %s: never checked, got cyc=%0d required cyc=%0d", nm, cyc_n, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
